// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset release sequencer: FSM state encoding
// and the active-high to output-polarity mapping.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Maps an active-high "reset asserted" level onto the pin level.
    function automatic logic out_level(input logic asserted, input logic inverted);
        return asserted ^ inverted;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit. The reset value
// is a parameter so the chain can be preset to a safe level.
module bit_synchronizer #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_chain;

    // Shift the raw bit through the chain; reset presets every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= {DEPTH{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Per-domain reset generator. Synchronizes a raw reset request, holds all
// outputs asserted for a minimum width, then releases them one at a time
// in index order, STAGGER_CYCLES apart. Any new request reasserts all
// outputs together and restarts the sequence.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_ASSERT  | all outputs asserted; counting deasserted request cycles
// ST_RELEASE | output 0 released; releasing the rest every STAGGER cycles
// ST_RUN     | every output released; all_released high
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int   SYNC_STAGES       = 2,
    parameter int   MIN_ASSERT_CYCLES = 16,
    parameter int   NUM_OUTPUTS       = 3,
    parameter int   STAGGER_CYCLES    = 2,
    parameter logic req_inverted      = 1'b1,
    parameter logic out_inverted      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_in,
    output logic [NUM_OUTPUTS-1:0] rst_out,
    output logic                   all_released
);

    localparam int CNT_W  = $clog2(MIN_ASSERT_CYCLES + 1);
    localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
    localparam int IDX_W  = $clog2(NUM_OUTPUTS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_OUTPUTS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    localparam logic                   ASSERT_LVL   = out_level(1'b1, out_inverted);
    localparam logic [NUM_OUTPUTS-1:0] RST_ASSERTED = {NUM_OUTPUTS{ASSERT_LVL}};

    logic                   w_req_norm;
    logic                   w_req_sync;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [STAG_W-1:0]      r_stag;
    logic [STAG_W-1:0]      w_stag_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;

    // r_rel is the active-high "this output is released" mask.
    logic [NUM_OUTPUTS-1:0] r_rel;
    logic [NUM_OUTPUTS-1:0] w_rel_nxt;
    logic [NUM_OUTPUTS-1:0] w_rst_nxt;
    logic [NUM_OUTPUTS-1:0] r_rst_out;
    logic                   r_all_released;

    assign w_req_norm = req_in ^ req_inverted;

    bit_synchronizer #(
        .DEPTH     (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_req_norm),
        .o_q   (w_req_sync)
    );

    // Next-state, counter and release-mask logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stag_nxt  = r_stag;
        w_idx_nxt   = r_idx;
        w_rel_nxt   = r_rel;

        case (r_state)
            ST_ASSERT: begin
                w_rel_nxt = '0;
                if (w_req_sync) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    // cnt stays put here; leaving ASSERT is what stops it.
                    w_rel_nxt[0] = 1'b1;
                    if (NUM_OUTPUTS == 1) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                        w_idx_nxt   = IDX_ONE;
                        w_stag_nxt  = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (w_req_sync) begin
                    // A fresh request beats a release due on this edge.
                    w_state_nxt = ST_ASSERT;
                    w_rel_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (r_stag == STAG_LAST) begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (IDX_W'(i) == r_idx) begin
                            w_rel_nxt[i] = 1'b1;
                        end
                    end
                    w_stag_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_stag_nxt = r_stag + 1'b1;
                end
            end

            ST_RUN: begin
                if (w_req_sync) begin
                    w_state_nxt = ST_ASSERT;
                    w_rel_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_ASSERT;
                w_rel_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Convert the next release mask to pin polarity so outputs come straight from flops.
    always_comb begin
        w_rst_nxt = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            w_rst_nxt[i] = out_level(~w_rel_nxt[i], out_inverted);
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_ASSERT;
            r_cnt          <= '0;
            r_stag         <= '0;
            r_idx          <= '0;
            r_rel          <= '0;
            r_rst_out      <= RST_ASSERTED;
            r_all_released <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_stag         <= w_stag_nxt;
            r_idx          <= w_idx_nxt;
            r_rel          <= w_rel_nxt;
            r_rst_out      <= w_rst_nxt;
            r_all_released <= (w_state_nxt == ST_RUN);
        end
    end

    assign rst_out      = r_rst_out;
    assign all_released = r_all_released;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: a three-output instance and a
// single-output instance share clock, reset and request. Each edge's
// expected outputs are queued when the inputs are driven and compared
// just after the rising edge.
module tb_reset_release_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_in = 1'b1;
    logic [2:0] rst_out;
    logic       all_released;
    logic [0:0] rst_out_s;
    logic       all_released_s;

    always #5 clk = ~clk;

    reset_release_sequencer #(
        .SYNC_STAGES       (2),
        .MIN_ASSERT_CYCLES (4),
        .NUM_OUTPUTS       (3),
        .STAGGER_CYCLES    (2),
        .req_inverted      (1'b1),
        .out_inverted      (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_in       (req_in),
        .rst_out      (rst_out),
        .all_released (all_released)
    );

    reset_release_sequencer #(
        .SYNC_STAGES       (2),
        .MIN_ASSERT_CYCLES (4),
        .NUM_OUTPUTS       (1),
        .STAGGER_CYCLES    (1),
        .req_inverted      (1'b1),
        .out_inverted      (1'b1)
    ) dut_s (
        .clk          (clk),
        .reset        (reset),
        .req_in       (req_in),
        .rst_out      (rst_out_s),
        .all_released (all_released_s)
    );

    typedef struct {
        int         tag;
        logic       rst;
        logic       req;
        int         n;
        logic [2:0] e_rst;
        logic       e_all;
        logic       e_rst_s;
        logic       e_all_s;
    } seg_t;

    typedef struct {
        int         tag;
        int         edge_no;
        logic [2:0] rst;
        logic       all;
        logic       rst_s;
        logic       all_s;
    } exp_t;

    seg_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_no = 0;

    // Drive one edge worth of inputs, queue the expectation, compare after the edge.
    task automatic step(input int tag, input logic r, input logic q,
                        input logic [2:0] er, input logic ea,
                        input logic ers, input logic eas);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset  = r;
        req_in = q;
        edge_no++;
        e.tag = tag; e.edge_no = edge_no;
        e.rst = er; e.all = ea; e.rst_s = ers; e.all_s = eas;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        checks++;
        if (rst_out !== g.rst || all_released !== g.all) begin
            errors++;
            $display("FAIL main_outputs tag=%0d edge=%0d: got rst_out=%b all_released=%b, want rst_out=%b all_released=%b",
                     g.tag, g.edge_no, rst_out, all_released, g.rst, g.all);
        end
        checks++;
        if (rst_out_s[0] !== g.rst_s || all_released_s !== g.all_s) begin
            errors++;
            $display("FAIL single_outputs tag=%0d edge=%0d: got rst_out=%b all_released=%b, want rst_out=%b all_released=%b",
                     g.tag, g.edge_no, rst_out_s[0], all_released_s, g.rst_s, g.all_s);
        end
    endtask

    initial begin
        // 1: power-up; e1 is the first edge with reset low.
        tbl.push_back('{1, 1'b1, 1'b1, 3, 3'b000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b0, 1'b1, 5, 3'b000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 1'b0, 1'b1, 2, 3'b001, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1, 1'b0, 1'b1, 2, 3'b011, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1, 1'b0, 1'b1, 3, 3'b111, 1'b1, 1'b1, 1'b1});
        // 2: one-cycle request in RUN; assert three edges later, full restart.
        tbl.push_back('{2, 1'b0, 1'b0, 1, 3'b111, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{2, 1'b0, 1'b1, 1, 3'b111, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{2, 1'b0, 1'b1, 4, 3'b000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2, 1'b0, 1'b1, 2, 3'b001, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{2, 1'b0, 1'b1, 2, 3'b011, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{2, 1'b0, 1'b1, 2, 3'b111, 1'b1, 1'b1, 1'b1});
        // 3: request reaches req_sync on the edge bit 1 was due; bit 1 never releases.
        tbl.push_back('{3, 1'b0, 1'b0, 1, 3'b111, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{3, 1'b0, 1'b1, 1, 3'b111, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{3, 1'b0, 1'b1, 4, 3'b000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 1'b0, 1'b0, 1, 3'b001, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{3, 1'b0, 1'b1, 1, 3'b001, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{3, 1'b0, 1'b1, 4, 3'b000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 1'b0, 1'b1, 2, 3'b001, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{3, 1'b0, 1'b1, 2, 3'b011, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{3, 1'b0, 1'b1, 2, 3'b111, 1'b1, 1'b1, 1'b1});
        // 4: request held 20 cycles.
        tbl.push_back('{4, 1'b0, 1'b0, 2,  3'b111, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{4, 1'b0, 1'b0, 18, 3'b000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4, 1'b0, 1'b1, 5,  3'b000, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{4, 1'b0, 1'b1, 2,  3'b001, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4, 1'b0, 1'b1, 2,  3'b011, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{4, 1'b0, 1'b1, 2,  3'b111, 1'b1, 1'b1, 1'b1});

        foreach (tbl[s]) begin
            for (int k = 0; k < tbl[s].n; k++) begin
                step(tbl[s].tag, tbl[s].rst, tbl[s].req,
                     tbl[s].e_rst, tbl[s].e_all, tbl[s].e_rst_s, tbl[s].e_all_s);
            end
        end

        // 5: reset pulse right after bit 0 releases; restart from the synchronizer preset.
        step(5, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 1'b1);
        step(5, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(5, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(5, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1);
        step(5, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(5, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) step(5, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) step(5, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) step(5, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1);

        // 6: reset and request together; reset wins and a held request keeps outputs down.
        step(6, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) step(6, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(6, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(6, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
